uart_rx_sb_ctrl: RTL and testbench

UART receiver with a system-bus register interface, mirroring the existing UART transmitter controller on the peripheral bus. It oversamples the serial line with a fractional baud accumulator, deframes 8N1/8E1/8N2/8E2 frames LSB-first and holds the last byte in a read register. It flags parity, framing and overrun errors and raises an interrupt while data is pending.

---
 rtl/uart_rx_sb_ctrl.sv | 170 +++++++++++++++++
 tb/tb_uart_rx_sb_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_sb_ctrl.sv
// UART receiver (8N1/8E1/8N2/8E2) with a peripheral-bus register interface.
// Fractional baud accumulator, clear-on-read data/status, interrupt while data is pending.
module uart_rx_sb_ctrl #(
   parameter int unsigned CLK_FREQ = 10_000_000
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [31:0] addr_i,
   input  logic        req_i,
   input  logic        write_enable_i,
   input  logic [31:0] write_data_i,
   output logic [31:0] read_data_o,
   input  logic        rx_i,
   output logic        irq_o
);
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t      state;
   logic [31:0] baudrate;
   logic [31:0] acc;
   logic        parity_en;
   logic        stopbit;
   logic [7:0]  data;
   logic [7:0]  shreg;
   logic        valid;
   logic        busy;
   logic        parity_err;
   logic        frame_err;
   logic        overrun;
   logic        rx_meta;
   logic        rx_s;
   logic        rx_prev;
   logic [2:0]  bit_cnt;
   logic        stop_cnt;
   logic        perr;
   logic        ferr;

   logic        rd;
   logic        wr;
   logic        soft_rst;
   logic        fall;
   logic        tick;
   logic        ferr_now;
   logic [32:0] acc_next;
   logic [31:0] acc_wrap;

   assign rd       = req_i & ~write_enable_i;
   assign wr       = req_i & write_enable_i;
   assign soft_rst = wr && (addr_i == 32'h24);
   assign fall     = rx_prev & ~rx_s;
   assign acc_next = {1'b0, acc} + {1'b0, baudrate};
   // acc_next < 2*CLK_FREQ fits in 32 bits after the subtraction, so the low word suffices
   assign acc_wrap = acc_next[31:0] - 32'(CLK_FREQ);
   assign tick     = (state != IDLE) && (acc_next >= 33'(CLK_FREQ));
   assign ferr_now = ferr | ~rx_s;
   assign irq_o    = valid;

   always_comb begin
      read_data_o = '0;
      if (rd) begin
         case (addr_i)
            32'h00:  read_data_o = {24'b0, data};
            32'h04:  read_data_o = {31'b0, valid};
            32'h08:  read_data_o = {31'b0, busy};
            32'h0C:  read_data_o = baudrate;
            32'h10:  read_data_o = {31'b0, parity_en};
            32'h14:  read_data_o = {31'b0, stopbit};
            32'h18:  read_data_o = {29'b0, overrun, frame_err, parity_err};
            default: read_data_o = '0;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state <= IDLE;       baudrate <= 32'd9600;  acc <= '0;
         parity_en <= 1'b1;   stopbit <= 1'b1;
         data <= '0;          shreg <= '0;           valid <= 1'b0;
         busy <= 1'b0;        parity_err <= 1'b0;    frame_err <= 1'b0;
         overrun <= 1'b0;     rx_meta <= 1'b1;       rx_s <= 1'b1;
         rx_prev <= 1'b1;     bit_cnt <= '0;         stop_cnt <= 1'b0;
         perr <= 1'b0;        ferr <= 1'b0;
      end else if (soft_rst) begin
         state <= IDLE;       baudrate <= 32'd9600;  acc <= '0;
         parity_en <= 1'b1;   stopbit <= 1'b1;
         data <= '0;          shreg <= '0;           valid <= 1'b0;
         busy <= 1'b0;        parity_err <= 1'b0;    frame_err <= 1'b0;
         overrun <= 1'b0;     rx_meta <= 1'b1;       rx_s <= 1'b1;
         rx_prev <= 1'b1;     bit_cnt <= '0;         stop_cnt <= 1'b0;
         perr <= 1'b0;        ferr <= 1'b0;
      end else begin
         rx_meta <= rx_i;
         rx_s    <= rx_meta;
         rx_prev <= rx_s;

         if (wr && !busy) begin
            case (addr_i)
               32'h0C:  if (write_data_i != '0) baudrate <= write_data_i;
               32'h10:  parity_en <= write_data_i[0];
               32'h14:  stopbit <= write_data_i[0];
               default: ;
            endcase
         end

         // clears first so that a same-cycle commit below takes precedence
         if (rd && addr_i == 32'h00) valid <= 1'b0;
         if (rd && addr_i == 32'h18) begin
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
         end

         if (state != IDLE) acc <= tick ? acc_wrap : acc_next[31:0];

         case (state)
            IDLE: begin
               if (fall) begin
                  acc   <= 32'(CLK_FREQ / 2);
                  busy  <= 1'b1;
                  state <= START;
               end
            end
            START: begin
               if (tick) begin
                  if (rx_s) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end else begin
                     state    <= DATA;
                     bit_cnt  <= '0;
                     stop_cnt <= 1'b0;
                     perr     <= 1'b0;
                     ferr     <= 1'b0;
                  end
               end
            end
            DATA: begin
               if (tick) begin
                  shreg[bit_cnt] <= rx_s;
                  bit_cnt        <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) state <= parity_en ? PARITY : STOP;
               end
            end
            PARITY: begin
               if (tick) begin
                  perr  <= rx_s ^ (^shreg);
                  state <= STOP;
               end
            end
            STOP: begin
               if (tick) begin
                  if (stopbit && !stop_cnt) begin
                     stop_cnt <= 1'b1;
                     ferr     <= ferr_now;
                  end else begin
                     data  <= shreg;
                     valid <= 1'b1;
                     busy  <= 1'b0;
                     state <= IDLE;
                     if (perr)     parity_err <= 1'b1;
                     if (ferr_now) frame_err  <= 1'b1;
                     if (valid)    overrun    <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_rx_sb_ctrl.sv
// Scoreboard bench for uart_rx_sb_ctrl: reads push expected values, a monitor
// compares every bus read response (data and irq) as it appears.
module tb_uart_rx_sb_ctrl;
   logic        clk;
   logic        rst_n;
   logic [31:0] addr;
   logic        req;
   logic        we;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        rx;
   logic        irq;

   int checks = 0;
   int errors = 0;
   time t_fall = 0;
   time t_irq  = 0;

   typedef struct {
      string       name;
      logic [31:0] data;
      logic        irq;
   } exp_t;
   exp_t sb[$];

   uart_rx_sb_ctrl #(.CLK_FREQ(1_000_000)) dut (
      .clk_i(clk), .rst_ni(rst_n), .addr_i(addr), .req_i(req),
      .write_enable_i(we), .write_data_i(wdata), .read_data_o(rdata),
      .rx_i(rx), .irq_o(irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge irq) t_irq = $time;

   // monitor: one sample per read cycle, 2ns after the driving negedge
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (req && !we) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_read addr=%h got data=%h", addr, rdata);
            end else begin
               e = sb.pop_front();
               if (rdata !== e.data || irq !== e.irq) begin
                  errors++;
                  $display("FAIL %s: got data=%h irq=%b, expected data=%h irq=%b",
                           e.name, rdata, irq, e.data, e.irq);
               end
            end
         end
      end
   end

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      req = 1'b1; we = 1'b1; addr = a; wdata = d;
      @(negedge clk);
      req = 1'b0; we = 1'b0;
   endtask

   task automatic bus_read(input string name, input logic [31:0] a,
                           input logic [31:0] exp_d, input logic exp_irq);
      exp_t e;
      e.name = name; e.data = exp_d; e.irq = exp_irq;
      sb.push_back(e);
      @(negedge clk);
      req = 1'b1; we = 1'b0; addr = a;
      @(negedge clk);
      req = 1'b0;
   endtask

   task automatic send(input logic [7:0] d, input bit par, input bit pbit,
                       input int nstop, input bit stop2);
      @(negedge clk);
      rx = 1'b0;
      t_fall = $time;
      repeat (10) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         repeat (10) @(negedge clk);
      end
      if (par) begin
         rx = pbit;
         repeat (10) @(negedge clk);
      end
      rx = 1'b1;
      repeat (10) @(negedge clk);
      if (nstop == 2) begin
         rx = stop2;
         repeat (10) @(negedge clk);
      end
      rx = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic wait_irq(input string name);
      bit seen = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (irq) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL %s: irq got 0 after 300 cycles, expected 1", name);
      end
   endtask

   initial begin
      rst_n = 1'b0; rx = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      bus_read("rst_baud",   32'h0C, 32'd9600, 1'b0);
      bus_read("rst_parity", 32'h10, 32'd1, 1'b0);
      bus_read("rst_stop",   32'h14, 32'd1, 1'b0);
      bus_read("rst_busy",   32'h08, 32'd0, 1'b0);
      bus_read("rst_valid",  32'h04, 32'd0, 1'b0);
      bus_read("rst_status", 32'h18, 32'd0, 1'b0);
      bus_read("unmapped",   32'h20, 32'd0, 1'b0);

      bus_write(32'h0C, 32'd100_000);
      bus_write(32'h10, 32'd0);
      bus_write(32'h14, 32'd0);
      bus_write(32'h0C, 32'd0);
      bus_write(32'h04, 32'd1);
      bus_read("baud_set",   32'h0C, 32'd100_000, 1'b0);
      bus_read("ro_write",   32'h04, 32'd0, 1'b0);

      // basic 8N1 frame
      fork
         send(8'hA5, 1'b0, 1'b0, 1, 1'b1);
         begin
            repeat (30) @(negedge clk);
            bus_read("busy_mid", 32'h08, 32'd1, 1'b0);
         end
      join
      wait_irq("basic_irq");
      checks++;
      if (t_irq - t_fall < 950 || t_irq - t_fall > 1000) begin
         errors++;
         $display("FAIL latency: got %0t, expected 950..1000 ns", t_irq - t_fall);
      end
      bus_read("valid_set",  32'h04, 32'd1, 1'b1);
      bus_read("data_a5",    32'h00, 32'hA5, 1'b1);
      bus_read("valid_clr",  32'h04, 32'd0, 1'b0);
      bus_read("no_err",     32'h18, 32'd0, 1'b0);

      // parity: 0x3C has even weight, so parity bit 1 is wrong
      bus_write(32'h10, 32'd1);
      send(8'h3C, 1'b1, 1'b1, 1, 1'b1);
      wait_irq("par_irq");
      bus_read("perr_set",   32'h18, 32'd1, 1'b1);
      bus_read("data_3c",    32'h00, 32'h3C, 1'b1);
      bus_read("perr_clr",   32'h18, 32'd0, 1'b0);
      send(8'h07, 1'b1, 1'b1, 1, 1'b1);
      wait_irq("par_ok_irq");
      bus_read("par_ok",     32'h18, 32'd0, 1'b1);
      bus_read("data_07",    32'h00, 32'h07, 1'b1);

      // two stop bits, second one low; config write mid-frame is blocked
      bus_write(32'h14, 32'd1);
      fork
         send(8'h81, 1'b1, 1'b0, 2, 1'b0);
         begin
            repeat (30) @(negedge clk);
            bus_write(32'h0C, 32'd50_000);
            bus_read("baud_locked", 32'h0C, 32'd100_000, 1'b0);
         end
      join
      wait_irq("ferr_irq");
      bus_read("ferr_set",   32'h18, 32'd2, 1'b1);
      bus_read("data_81",    32'h00, 32'h81, 1'b1);

      // false start then overrun
      bus_write(32'h10, 32'd0);
      bus_write(32'h14, 32'd0);
      @(negedge clk);
      rx = 1'b0;
      repeat (3) @(negedge clk);
      rx = 1'b1;
      repeat (20) @(negedge clk);
      bus_read("false_busy",  32'h08, 32'd0, 1'b0);
      bus_read("false_valid", 32'h04, 32'd0, 1'b0);
      send(8'h11, 1'b0, 1'b0, 1, 1'b1);
      send(8'h22, 1'b0, 1'b0, 1, 1'b1);
      wait_irq("ovr_irq");
      bus_read("data_22",    32'h00, 32'h22, 1'b1);
      bus_read("ovr_set",    32'h18, 32'd4, 1'b0);

      // soft reset during DATA with a byte still pending
      send(8'h33, 1'b0, 1'b0, 1, 1'b1);
      wait_irq("pend_irq");
      fork
         send(8'hFF, 1'b0, 1'b0, 1, 1'b1);
         begin
            repeat (40) @(negedge clk);
            bus_write(32'h24, 32'h0);
            bus_read("srst_busy",   32'h08, 32'd0, 1'b0);
            bus_read("srst_valid",  32'h04, 32'd0, 1'b0);
            bus_read("srst_data",   32'h00, 32'd0, 1'b0);
            bus_read("srst_baud",   32'h0C, 32'd9600, 1'b0);
            bus_read("srst_parity", 32'h10, 32'd1, 1'b0);
            bus_read("srst_stop",   32'h14, 32'd1, 1'b0);
         end
      join
      repeat (50) @(negedge clk);
      bus_read("srst_nocommit", 32'h04, 32'd0, 1'b0);
      bus_read("srst_idle",     32'h08, 32'd0, 1'b0);

      for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
      if (sb.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
